// File: rtl/idma_chunker_pkg.sv
// Shared types for the iDMA request chunker: FSM states, burst request, chunk sizing.
package idma_chunker_pkg;

  localparam int unsigned AddrW = 64;
  localparam int unsigned LenW  = 64;
  localparam int unsigned OptW  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SPLIT,
    DRAIN,
    DONE
  } chunker_state_e;

  typedef struct packed {
    logic [LenW-1:0]  length;
    logic [AddrW-1:0] src_addr;
    logic [AddrW-1:0] dst_addr;
    logic [OptW-1:0]  opt;
  } burst_req_t;

  function automatic logic [LenW-1:0] chunk_len(
    input logic [LenW-1:0] remaining,
    input logic [LenW-1:0] max_len
  );
    return (remaining < max_len) ? remaining : max_len;
  endfunction

endpackage

// File: rtl/idma_outstanding_cnt.sv
// Up/down counter of issued-but-uncompleted chunks with full/empty flags.
module idma_outstanding_cnt #(
  parameter int unsigned Max = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int unsigned W = $clog2(Max + 1);

  logic [W-1:0] count;
  logic         take;

  // A completion with nothing outstanding is dropped.
  assign take  = dec && !empty;
  assign full  = (count == W'(Max));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !take) begin
      count <= count + W'(1);
    end else if (!inc && take) begin
      count <= count - W'(1);
    end
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst) !(dec && empty)
  );

endmodule

// File: rtl/idma_req_chunker.sv
// Splits one burst at a time into ChunkBytes pieces; one completion pulse per burst.
// IDMA_CHUNKER_BYPASS_EN adds bypass_i to forward a burst as a single chunk.
module idma_req_chunker #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned LenWidth       = 64,
  parameter int unsigned ChunkBytes     = 4096,
  parameter int unsigned MaxOutstanding = 16,
  parameter type burst_req_t = idma_chunker_pkg::burst_req_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  burst_req_t req_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output burst_req_t req_o,
  output logic       req_valid_o,
  input  logic       req_ready_i,
  input  logic       chunk_done_i,
`ifdef IDMA_CHUNKER_BYPASS_EN
  input  logic       bypass_i,
`endif
  output logic       trans_complete_o,
  output logic       busy_o
);

  import idma_chunker_pkg::*;

  localparam logic [LenWidth-1:0] ChunkLen = LenWidth'(ChunkBytes);

  chunker_state_e state, next;
  burst_req_t     cur, chunk;
  logic [LenWidth-1:0] len;
  logic issue, last, full, empty, accept;

`ifdef IDMA_CHUNKER_BYPASS_EN
  logic byp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp <= 1'b0;
    end else if (accept) begin
      byp <= bypass_i;
    end
  end

  assign len = byp ? cur.length : chunk_len(cur.length, ChunkLen);
`else
  assign len = chunk_len(cur.length, ChunkLen);
`endif

  assign last   = (len == cur.length);
  assign accept = (state == IDLE) && req_valid_i && !rst_i;

  always_comb begin
    chunk        = cur;
    chunk.length = len;
  end

  idma_outstanding_cnt #(
    .Max (MaxOutstanding)
  ) u_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (issue),
    .dec   (chunk_done_i),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next             = state;
    req_ready_o      = 1'b0;
    req_valid_o      = 1'b0;
    req_o            = '0;
    trans_complete_o = 1'b0;
    busy_o           = 1'b0;
    issue            = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          next = (req_i.length != '0) ? SPLIT : DONE;
        end
      end
      SPLIT: begin
        busy_o      = 1'b1;
        req_o       = chunk;
        req_valid_o = !full;
        issue       = req_valid_o && req_ready_i;
        if (issue && last) begin
          next = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (empty) begin
          next = DONE;
        end
      end
      DONE: begin
        busy_o           = 1'b1;
        trans_complete_o = 1'b1;
        next             = IDLE;
      end
      default: next = IDLE;
    endcase
    // Outputs are quiet for the whole reset cycle, not just after it.
    if (rst_i) begin
      req_ready_o      = 1'b0;
      req_valid_o      = 1'b0;
      req_o            = '0;
      trans_complete_o = 1'b0;
      busy_o           = 1'b0;
      issue            = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur <= '0;
    end else if (accept) begin
      cur <= req_i;
    end else if (issue) begin
      cur.src_addr <= cur.src_addr + AddrWidth'(len);
      cur.dst_addr <= cur.dst_addr + AddrWidth'(len);
      cur.length   <= cur.length - len;
    end
  end

endmodule

// File: tb/tb_idma_req_chunker.sv
// Directed bench for idma_req_chunker: splitting, zero length, backpressure, wrap, reset.
module tb_idma_req_chunker;
  import idma_chunker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       a_rst, a_rv, a_rdy_o, a_vo, a_rdy_i, a_done, a_tc, a_busy;
  burst_req_t a_req, a_out;
  logic       b_rst, b_rv, b_rdy_o, b_vo, b_rdy_i, b_done, b_tc, b_busy;
  burst_req_t b_req, b_out;

  idma_req_chunker #(
    .ChunkBytes     (4096),
    .MaxOutstanding (2)
  ) dut_a (
    .clk_i            (clk),
    .rst_i            (a_rst),
    .req_i            (a_req),
    .req_valid_i      (a_rv),
    .req_ready_o      (a_rdy_o),
    .req_o            (a_out),
    .req_valid_o      (a_vo),
    .req_ready_i      (a_rdy_i),
    .chunk_done_i     (a_done),
`ifdef IDMA_CHUNKER_BYPASS_EN
    .bypass_i         (1'b0),
`endif
    .trans_complete_o (a_tc),
    .busy_o           (a_busy)
  );

  idma_req_chunker #(
    .ChunkBytes     (2048),
    .MaxOutstanding (16)
  ) dut_b (
    .clk_i            (clk),
    .rst_i            (b_rst),
    .req_i            (b_req),
    .req_valid_i      (b_rv),
    .req_ready_o      (b_rdy_o),
    .req_o            (b_out),
    .req_valid_o      (b_vo),
    .req_ready_i      (b_rdy_i),
    .chunk_done_i     (b_done),
`ifdef IDMA_CHUNKER_BYPASS_EN
    .bypass_i         (1'b0),
`endif
    .trans_complete_o (b_tc),
    .busy_o           (b_busy)
  );

  task automatic accept_a(input logic [63:0] len, input logic [63:0] src,
                          input logic [63:0] dst);
    @(negedge clk);
    checks++;
    if (a_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_a_ready: got %b want 1", a_rdy_o);
    end
    a_req.length   = len;
    a_req.src_addr = src;
    a_req.dst_addr = dst;
    a_req.opt      = 8'h5A;
    a_rv = 1'b1;
    @(negedge clk);
    a_rv = 1'b0;
  endtask

  task automatic drain_a(input int start, input int maxcyc, output int pulses);
    int pend;
    pend   = start;
    pulses = 0;
    for (int c = 0; c < maxcyc; c++) begin
      if (a_tc) pulses++;
      a_done = (pend > 0);
      if (pend > 0) pend--;
      if (a_vo && a_rdy_i) pend++;
      @(negedge clk);
    end
    a_done = 1'b0;
  endtask

  task automatic test_reset;
    a_rst = 1'b1;
    b_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_rdy_o, a_vo, a_tc, a_busy} !== 4'b0 || a_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b tc=%b busy=%b want all 0",
               a_rdy_o, a_vo, a_tc, a_busy);
    end
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rdy_o !== 1'b1 || a_busy !== 1'b0 || a_vo !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b busy=%b v=%b want 1 0 0",
               a_rdy_o, a_busy, a_vo);
    end
  endtask

  task automatic test_split;
    logic [63:0] exp_src [3];
    logic [63:0] exp_dst [3];
    logic [63:0] exp_len [3];
    int k, pulses, pend;
    exp_src = '{64'h1000, 64'h2000, 64'h3000};
    exp_dst = '{64'h8000, 64'h9000, 64'hA000};
    exp_len = '{64'd4096, 64'd4096, 64'd1808};
    k = 0;
    pulses = 0;
    pend = 0;
    a_rdy_i = 1'b1;
    accept_a(64'd10000, 64'h1000, 64'h8000);
    for (int c = 0; c < 30; c++) begin
      if (a_tc) pulses++;
      a_done = (pend > 0);
      if (pend > 0) pend--;
      if (a_vo) begin
        if (k < 3) begin
          checks++;
          if (a_out.src_addr !== exp_src[k] || a_out.dst_addr !== exp_dst[k] ||
              a_out.length !== exp_len[k]) begin
            errors++;
            $display("FAIL split_chunk%0d: got %h/%h/%0d want %h/%h/%0d", k,
                     a_out.src_addr, a_out.dst_addr, a_out.length,
                     exp_src[k], exp_dst[k], exp_len[k]);
          end
          checks++;
          if (a_out.opt !== 8'h5A) begin
            errors++;
            $display("FAIL split_opt%0d: got %h want 5a", k, a_out.opt);
          end
        end
        k++;
        pend++;
      end
      @(negedge clk);
    end
    a_done = 1'b0;
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL split_count: got %0d want 3", k);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL split_complete: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_zero_len;
    accept_a(64'd0, 64'h40, 64'h80);
    checks++;
    if (a_tc !== 1'b1 || a_busy !== 1'b1 || a_vo !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: got tc=%b busy=%b v=%b want 1 1 0",
               a_tc, a_busy, a_vo);
    end
    @(negedge clk);
    checks++;
    if (a_tc !== 1'b0 || a_busy !== 1'b0 || a_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_after: got tc=%b busy=%b rdy=%b want 0 0 1",
               a_tc, a_busy, a_rdy_o);
    end
  endtask

  task automatic test_max_outstanding;
    int hs, pulses;
    hs = 0;
    a_rdy_i = 1'b1;
    a_done = 1'b0;
    accept_a(64'd16384, 64'h10_0000, 64'h20_0000);
    for (int c = 0; c < 6; c++) begin
      if (a_vo) hs++;
      @(negedge clk);
    end
    checks++;
    if (hs !== 2 || a_vo !== 1'b0) begin
      errors++;
      $display("FAIL maxout_stall: got hs=%0d v=%b want 2 0", hs, a_vo);
    end
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    checks++;
    if (a_vo !== 1'b1 || a_out.src_addr !== 64'h10_2000) begin
      errors++;
      $display("FAIL maxout_resume: got v=%b src=%h want 1 102000",
               a_vo, a_out.src_addr);
    end
    drain_a(1, 40, pulses);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL maxout_complete: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic seen;
    a_rdy_i = 1'b1;
    accept_a(64'd8192, 64'h3000, 64'h7000);
    @(negedge clk);
    a_done = 1'b1;
    checks++;
    if (a_vo !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_valid: got %b want 1", a_vo);
    end
    @(negedge clk);
    a_done = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (a_tc || !a_busy || a_vo) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_premature: got early completion/idle want none");
    end
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    checks++;
    if (a_tc !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tc_early: got %b want 0", a_tc);
    end
    @(negedge clk);
    checks++;
    if (a_tc !== 1'b1) begin
      errors++;
      $display("FAIL b2b_tc: got %b want 1", a_tc);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_stall;
    burst_req_t snap;
    logic stable;
    int pend, pulses;
    b_rdy_i = 1'b0;
    b_done = 1'b0;
    @(negedge clk);
    b_req.length   = 64'd4096;
    b_req.src_addr = 64'hFFFF_FFFF_FFFF_F800;
    b_req.dst_addr = 64'h100;
    b_req.opt      = 8'h33;
    b_rv = 1'b1;
    @(negedge clk);
    b_rv = 1'b0;
    snap = b_out;
    checks++;
    if (b_vo !== 1'b1 || b_out.src_addr !== 64'hFFFF_FFFF_FFFF_F800 ||
        b_out.length !== 64'd2048) begin
      errors++;
      $display("FAIL wrap_first: got v=%b src=%h len=%0d want 1 fffffffffffff800 2048",
               b_vo, b_out.src_addr, b_out.length);
    end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (b_out !== snap || b_vo !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL wrap_stable: got req_o changed under stall want held");
    end
    b_rdy_i = 1'b1;
    @(negedge clk);
    b_rdy_i = 1'b0;
    checks++;
    if (b_out.src_addr !== 64'h0 || b_out.dst_addr !== 64'h900 ||
        b_out.length !== 64'd2048) begin
      errors++;
      $display("FAIL wrap_second: got %h/%h/%0d want 0/900/2048",
               b_out.src_addr, b_out.dst_addr, b_out.length);
    end
    b_rdy_i = 1'b1;
    pend = 1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (b_tc) pulses++;
      b_done = (pend > 0);
      if (pend > 0) pend--;
      if (b_vo) pend++;
      @(negedge clk);
    end
    b_done = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL wrap_complete: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    a_rdy_i = 1'b1;
    a_done = 1'b0;
    accept_a(64'd16384, 64'h5000, 64'h6000);
    @(negedge clk);
    a_rst = 1'b1;
    #1;
    checks++;
    if ({a_rdy_o, a_vo, a_tc, a_busy} !== 4'b0 || a_out !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got rdy=%b v=%b tc=%b busy=%b want all 0",
               a_rdy_o, a_vo, a_tc, a_busy);
    end
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rdy_o !== 1'b1 || a_busy !== 1'b0 || a_vo !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got rdy=%b busy=%b v=%b want 1 0 0",
               a_rdy_o, a_busy, a_vo);
    end
    accept_a(64'd4096, 64'h0, 64'h0);
    drain_a(0, 20, pulses);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL rstmid_counter: got %0d pulses want 1", pulses);
    end
  endtask

  initial begin
    a_rst = 1'b1;
    a_rv = 1'b0;
    a_rdy_i = 1'b0;
    a_done = 1'b0;
    a_req = '0;
    b_rst = 1'b1;
    b_rv = 1'b0;
    b_rdy_i = 1'b0;
    b_done = 1'b0;
    b_req = '0;
    test_reset();
    test_split();
    test_zero_len();
    test_max_outstanding();
    test_back_to_back();
    test_wrap_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
